// File: rtl/matrix_pkg.sv
// Constants and state encoding shared by the scroll sequencer and the frame serializer.
package matrix_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        ADVANCE
    } state_t;

    localparam int                 SHIFT_W   = 3;
    localparam logic [SHIFT_W-1:0] SHIFT_MAX = 3'd7;

    localparam int DEF_GLYPH_W     = 4;
    localparam int DEF_BLANK_GLYPH = 0;

endpackage

// File: rtl/glyph_fifo.sv
// Synchronous glyph queue: no bypass, a push while full is refused, push and pop may coincide.
module glyph_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // NOTE: storage is deliberately not reset; the count alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= i_data;
    end

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/matrix_scroll_sequencer.sv
// Frame-by-frame scroll sequencer for the 8x8 LED matrix serializer, fed by a glyph queue.
module matrix_scroll_sequencer
    import matrix_pkg::*;
#(
    parameter int GLYPH_W     = DEF_GLYPH_W,
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_FRAMES = 1,
    parameter int BLANK_GLYPH = DEF_BLANK_GLYPH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          char_valid,
    input  logic [GLYPH_W-1:0]            char_code,
    output logic                          char_ready,
    output logic                          frame_start,
    input  logic                          frame_done,
    output logic [GLYPH_W-1:0]            glyph_cur,
    output logic [GLYPH_W-1:0]            glyph_next,
    output logic [SHIFT_W-1:0]            shift,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam logic [GLYPH_W-1:0] BLANK_VAL = GLYPH_W'(BLANK_GLYPH);
    localparam int                 HOLD_W    = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

    state_t               r_state;
    logic                 r_frame_start;
    logic                 r_busy;
    logic [GLYPH_W-1:0]   r_glyph_cur;
    logic [GLYPH_W-1:0]   r_glyph_next;
    logic [SHIFT_W-1:0]   r_shift;
    logic [HOLD_W-1:0]    r_hold_cnt;

    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [GLYPH_W-1:0]   w_fifo_data;
    logic                 w_parked;
    logic                 w_pop;

    assign w_parked = (r_glyph_cur == BLANK_VAL) && (r_glyph_next == BLANK_VAL) && (r_shift == '0);
    assign w_pop    = (r_state == ADVANCE) && !w_fifo_empty && (w_parked || r_shift == SHIFT_MAX);

    glyph_fifo #(
        .WIDTH (GLYPH_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (char_valid),
        .i_data  (char_code),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (fifo_count)
    );

    // NOTE: every register here is next-state, so only non-blocking assignments are used.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_frame_start <= 1'b0;
            r_busy        <= 1'b0;
            r_glyph_cur   <= BLANK_VAL;
            r_glyph_next  <= BLANK_VAL;
            r_shift       <= '0;
            r_hold_cnt    <= '0;
        end else begin
            r_frame_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_state       <= START;
                        r_frame_start <= 1'b1;
                        r_busy        <= 1'b1;
                    end
                end
                START: r_state <= WAIT;
                WAIT: begin
                    if (frame_done) begin
                        if (r_hold_cnt == HOLD_LAST) begin
                            r_hold_cnt <= '0;
                            r_state    <= ADVANCE;
                        end else if (enable) begin
                            r_hold_cnt    <= r_hold_cnt + 1'b1;
                            r_state       <= START;
                            r_frame_start <= 1'b1;
                        end else begin
                            r_hold_cnt <= '0;
                            r_state    <= IDLE;
                            r_busy     <= 1'b0;
                        end
                    end
                end
                ADVANCE: begin
                    // A parked display only wakes up when a glyph is queued.
                    if (w_parked) begin
                        if (!w_fifo_empty)
                            r_glyph_next <= w_fifo_data;
                    end else if (r_shift != SHIFT_MAX) begin
                        r_shift <= r_shift + 1'b1;
                    end else begin
                        r_glyph_cur  <= r_glyph_next;
                        r_shift      <= '0;
                        r_glyph_next <= w_fifo_empty ? BLANK_VAL : w_fifo_data;
                    end
                    r_state       <= enable ? START : IDLE;
                    r_frame_start <= enable;
                    r_busy        <= enable;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign char_ready  = !w_fifo_full;
    assign frame_start = r_frame_start;
    assign busy        = r_busy;
    assign glyph_cur   = r_glyph_cur;
    assign glyph_next  = r_glyph_next;
    assign shift       = r_shift;

endmodule

// File: tb/tb_matrix_scroll_sequencer.sv
// Bench for matrix_scroll_sequencer: directed table on a HOLD_FRAMES=1 instance, randomized run with a queue model on a HOLD_FRAMES=3 instance.
module tb_matrix_scroll_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Instance 1: HOLD_FRAMES = 1
    logic       rst1 = 1'b1, en1 = 1'b0, valid1 = 1'b0, done1 = 1'b0;
    logic [3:0] code1 = '0;
    logic       rdy1, fs1, busy1;
    logic [3:0] cur1, nxt1;
    logic [2:0] sh1, cnt1;

    matrix_scroll_sequencer #(.GLYPH_W(4), .FIFO_DEPTH(4), .HOLD_FRAMES(1), .BLANK_GLYPH(0)) dut1 (
        .clk(clk), .reset(rst1), .enable(en1), .char_valid(valid1), .char_code(code1),
        .char_ready(rdy1), .frame_start(fs1), .frame_done(done1), .glyph_cur(cur1),
        .glyph_next(nxt1), .shift(sh1), .busy(busy1), .fifo_count(cnt1)
    );

    // Instance 3: HOLD_FRAMES = 3
    logic       rst3 = 1'b1, en3 = 1'b0, valid3 = 1'b0, done3 = 1'b0;
    logic [3:0] code3 = '0;
    logic       rdy3, fs3, busy3;
    logic [3:0] cur3, nxt3;
    logic [2:0] sh3, cnt3;

    matrix_scroll_sequencer #(.GLYPH_W(4), .FIFO_DEPTH(4), .HOLD_FRAMES(3), .BLANK_GLYPH(0)) dut3 (
        .clk(clk), .reset(rst3), .enable(en3), .char_valid(valid3), .char_code(code3),
        .char_ready(rdy3), .frame_start(fs3), .frame_done(done3), .glyph_cur(cur3),
        .glyph_next(nxt3), .shift(sh3), .busy(busy3), .fifo_count(cnt3)
    );

    typedef struct {
        logic       push;
        logic [3:0] code;
        logic [3:0] exp_cur;
        logic [3:0] exp_next;
        logic [2:0] exp_shift;
    } frame_vec_t;

    frame_vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic await_start1();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (fs1) seen = 1'b1;
        end
        check("start_seen", 32'(seen), 1);
    endtask

    task automatic finish_frame1(input logic push, input logic [3:0] code);
        if (push) begin
            @(posedge clk); #1 valid1 = 1'b1; code1 = code;
            @(posedge clk); #1 valid1 = 1'b0; done1 = 1'b1;
        end else begin
            @(posedge clk); #1 done1 = 1'b1;
        end
        @(posedge clk); #1 done1 = 1'b0;
    endtask

    task automatic check_scroll1(input string name, input logic [3:0] c, input logic [3:0] n, input logic [2:0] s);
        check({name, "_cur"},   32'(cur1), 32'(c));
        check({name, "_next"},  32'(nxt1), 32'(n));
        check({name, "_shift"}, 32'(sh1),  32'(s));
    endtask

    // Reference model for the randomized run: scroll position plus a plain glyph queue.
    logic [3:0] q[$];
    logic [3:0] m_cur, m_nxt;
    int         m_sh, m_fc, frames3;
    bit         adv_pending, outstanding;
    int         countdown;

    task automatic model_step();
        if (m_cur == 0 && m_nxt == 0 && m_sh == 0) begin
            if (q.size() > 0) m_nxt = q.pop_front();
        end else if (m_sh < 7) begin
            m_sh++;
        end else begin
            m_cur = m_nxt;
            m_sh  = 0;
            m_nxt = (q.size() > 0) ? q.pop_front() : 4'd0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;

        vecs[0] = '{1'b0, 4'd0, 4'd0, 4'd0, 3'd0};
        vecs[1] = '{1'b0, 4'd0, 4'd0, 4'd0, 3'd0};
        vecs[2] = '{1'b1, 4'd2, 4'd0, 4'd2, 3'd0};
        for (int s = 1; s <= 7; s++)
            vecs[2+s] = '{1'b0, 4'd0, 4'd0, 4'd2, 3'(s)};
        vecs[10] = '{1'b0, 4'd0, 4'd2, 4'd0, 3'd0};
        vecs[11] = '{1'b0, 4'd0, 4'd2, 4'd0, 3'd1};

        // ---- Reset values
        @(posedge clk); @(posedge clk); #1 rst1 = 1'b0;
        @(negedge clk);
        check("rst_frame_start", 32'(fs1), 0);
        check("rst_busy", 32'(busy1), 0);
        check_scroll1("rst", 4'd0, 4'd0, 3'd0);
        check("rst_count", 32'(cnt1), 0);
        check("rst_ready", 32'(rdy1), 1);

        // ---- Start latency
        @(posedge clk); #1 en1 = 1'b1;
        @(negedge clk);
        check("start_not_yet", 32'(fs1), 0);
        @(negedge clk);
        check("start_latency", 32'(fs1), 1);
        check("busy_running", 32'(busy1), 1);
        check_scroll1("first_frame", 4'd0, 4'd0, 3'd0);

        // ---- Table: parked frames, push 2, full 8-step scroll
        for (int i = 0; i < 12; i++) begin
            finish_frame1(vecs[i].push, vecs[i].code);
            await_start1();
            check_scroll1($sformatf("vec%0d", i), vecs[i].exp_cur, vecs[i].exp_next, vecs[i].exp_shift);
        end

        // ---- enable dropped during WAIT: frame completes, then idle with position kept
        @(posedge clk); #1 en1 = 1'b0; done1 = 1'b1;
        @(posedge clk); #1 done1 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (fs1) seen = 1'b1;
        end
        check("no_start_when_disabled", 32'(seen), 0);
        check("idle_busy", 32'(busy1), 0);
        check_scroll1("idle_kept", 4'd2, 4'd0, 3'd2);

        // ---- Fill FIFO while idle; 5th push stalls
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1 valid1 = 1'b1; code1 = 4'(7 + i);
            @(negedge clk);
            check($sformatf("fill_count%0d", i), 32'(cnt1), 32'(i));
        end
        @(posedge clk); #1 code1 = 4'd11;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("full_count", 32'(cnt1), 4);
            check("full_ready", 32'(rdy1), 0);
            @(posedge clk); #1;
        end

        // ---- Re-enable resumes from the retained position
        en1 = 1'b1;
        await_start1();
        check_scroll1("resume", 4'd2, 4'd0, 3'd2);
        for (int i = 0; i < 5; i++) begin
            finish_frame1(1'b0, 4'd0);
            await_start1();
        end
        check_scroll1("pre_pop", 4'd2, 4'd0, 3'd7);

        // ---- First pop: stalled entry accepted the cycle after
        @(posedge clk); #1 done1 = 1'b1;
        @(posedge clk); #1 done1 = 1'b0;
        @(negedge clk);
        check("adv_count", 32'(cnt1), 4);
        check("adv_ready", 32'(rdy1), 0);
        @(negedge clk);
        check("pop_start", 32'(fs1), 1);
        check("pop_count", 32'(cnt1), 3);
        check("pop_ready", 32'(rdy1), 1);
        check_scroll1("pop", 4'd0, 4'd7, 3'd0);
        @(posedge clk); #1 valid1 = 1'b0;
        @(negedge clk);
        check("refill_count", 32'(cnt1), 4);
        check("refill_ready", 32'(rdy1), 0);

        // ---- Order preserved
        for (int i = 0; i < 8; i++) begin
            finish_frame1(1'b0, 4'd0);
            await_start1();
        end
        check_scroll1("order_a", 4'd7, 4'd8, 3'd0);
        for (int i = 0; i < 8; i++) begin
            finish_frame1(1'b0, 4'd0);
            await_start1();
        end
        check_scroll1("order_b", 4'd8, 4'd9, 3'd0);
        for (int i = 0; i < 4; i++) begin
            finish_frame1(1'b0, 4'd0);
            await_start1();
        end
        check_scroll1("pre_reset", 4'd8, 4'd9, 3'd4);
        check("pre_reset_count", 32'(cnt1), 2);

        // ---- Reset during WAIT, then stray frame_done
        @(posedge clk); #1 rst1 = 1'b1; en1 = 1'b0;
        @(posedge clk); #1 rst1 = 1'b0;
        @(negedge clk);
        check("mid_rst_frame_start", 32'(fs1), 0);
        check("mid_rst_busy", 32'(busy1), 0);
        check_scroll1("mid_rst", 4'd0, 4'd0, 3'd0);
        check("mid_rst_count", 32'(cnt1), 0);
        check("mid_rst_ready", 32'(rdy1), 1);
        @(posedge clk); #1 done1 = 1'b1;
        @(posedge clk); #1 done1 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (fs1) seen = 1'b1;
        end
        check("stray_done_start", 32'(seen), 0);
        check("stray_done_busy", 32'(busy1), 0);
        check_scroll1("stray_done", 4'd0, 4'd0, 3'd0);

        // ---- Randomized run on HOLD_FRAMES=3 instance
        m_cur = 0; m_nxt = 0; m_sh = 0; m_fc = 0; frames3 = 0;
        adv_pending = 1'b0; outstanding = 1'b0; countdown = 0;
        @(posedge clk); @(posedge clk); #1 rst3 = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            int old_size;
            @(posedge clk);
            old_size = q.size();
            if (adv_pending) model_step();
            if (valid3 && old_size < 4) q.push_back(code3);
            adv_pending = 1'b0;
            if (done3) begin
                m_fc++;
                if (m_fc == 3) begin
                    m_fc = 0;
                    adv_pending = 1'b1;
                end else if (!en3) begin
                    m_fc = 0;
                end
            end
            #1;
            if (cyc == 0) en3 = 1'b1;
            else if ($urandom_range(0, 99) < 3) en3 = ~en3;
            valid3 = ($urandom_range(0, 5) == 0);
            code3  = 4'($urandom_range(0, 15));
            if (outstanding && countdown == 0) begin
                done3 = 1'b1;
                outstanding = 1'b0;
            end else begin
                done3 = 1'b0;
                if (outstanding) countdown--;
            end
            @(negedge clk);
            check("rnd_count", 32'(cnt3), 32'(q.size()));
            check("rnd_ready", 32'(rdy3), 32'(q.size() < 4));
            if (outstanding || fs3) begin
                check("rnd_cur",   32'(cur3), 32'(m_cur));
                check("rnd_next",  32'(nxt3), 32'(m_nxt));
                check("rnd_shift", 32'(sh3),  32'(m_sh));
            end
            if (fs3) begin
                check("rnd_no_double_start", 32'(outstanding), 0);
                outstanding = 1'b1;
                countdown = $urandom_range(0, 3);
                frames3++;
            end
        end
        check("rnd_progress", 32'(frames3 > 200), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
